// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the CPU
//   datapath and a multi-cycle 32-bit data memory. Hits are served without
//   stalling. Misses stall the CPU (BUSYWAIT) while the victim block is
//   written back (if dirty) and the requested block is fetched.
// Ports
//   CLK, RESET            clock; asynchronous active-high reset
//   READ, WRITE           CPU load/store request levels (WRITE wins if both)
//   ADDRESS, WRITEDATA    CPU byte address {tag,index,offset}; store byte
//   READDATA, BUSYWAIT    load byte; CPU stall
//   MEM_READ, MEM_WRITE   block fetch / write-back requests
//   MEM_ADDRESS           block address {tag,index}
//   MEM_WRITEDATA         victim block (byte0 in [7:0])
//   MEM_READDATA          fetched block (byte0 in [7:0])
//   MEM_BUSYWAIT          memory busy handshake
module dcache_controller #(
  parameter int ADDR_W   = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            READ,
  input  logic                            WRITE,
  input  logic [ADDR_W-1:0]               ADDRESS,
  input  logic [7:0]                      WRITEDATA,
  output logic [7:0]                      READDATA,
  output logic                            BUSYWAIT,
  output logic                            MEM_READ,
  output logic                            MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0]      MEM_ADDRESS,
  output logic [(8<<OFFSET_W)-1:0]        MEM_WRITEDATA,
  input  logic [(8<<OFFSET_W)-1:0]        MEM_READDATA,
  input  logic                            MEM_BUSYWAIT
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NBLK   = 1 << INDEX_W;
  localparam int BLK_W  = 8 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

  state_t state, next_state;

  logic [BLK_W-1:0] data [NBLK];
  logic [TAG_W-1:0] tags [NBLK];
  logic [NBLK-1:0]  valid;
  logic [NBLK-1:0]  dirty;

  logic [TAG_W-1:0]    tag_in;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic [BLK_W-1:0]    blk;
  logic                hit;
  logic                req;
  logic                write_hit;

  assign tag_in    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx       = ADDRESS[OFFSET_W +: INDEX_W];
  assign off       = ADDRESS[OFFSET_W-1:0];
  assign blk       = data[idx];
  assign hit       = valid[idx] && (tags[idx] == tag_in);
  assign req       = READ || WRITE;
  assign write_hit = (state == IDLE) && WRITE && hit;

  // Reset is folded in so the stall drops the moment RESET rises, even while
  // the CPU still holds its request.
  assign BUSYWAIT = !RESET && req && !((state == IDLE) && hit);

  always_comb begin
    READDATA = '0;
    if (hit) READDATA = blk[{off, 3'b000} +: 8];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (req && !hit) next_state = dirty[idx] ? WRITE_BACK : FETCH;
      end
      WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = blk;
        if (!MEM_BUSYWAIT) next_state = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, idx};
        if (!MEM_BUSYWAIT) next_state = UPDATE;
      end
      UPDATE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Data/tag storage carries no reset; only valid/dirty qualify its contents.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data[idx] <= MEM_READDATA;
      tags[idx] <= tag_in;
    end else if (write_hit) begin
      data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_op_t;

  mem_op_t    mem_q [$];
  logic [7:0] rd_q  [$];

  dcache_controller #(.ADDR_W(8), .INDEX_W(3), .OFFSET_W(2)) dut (
    .CLK(clk), .RESET(rst), .READ(read), .WRITE(write), .ADDRESS(address),
    .WRITEDATA(writedata), .READDATA(readdata), .BUSYWAIT(busywait),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata),
    .MEM_BUSYWAIT(mem_busywait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask

  // Memory model: busy for LAT cycles per request, then completes.
  logic [31:0] mem [64];
  int          cnt;
  assign mem_busywait = (mem_read || mem_write) && (cnt != LAT);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0;
    end else if (mem_read || mem_write) begin
      if (cnt == LAT) begin
        cnt = 0;
        if (mem_write) mem[mem_address] = mem_writedata;
        else           mem_readdata = mem[mem_address];
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // Memory-side scoreboard: compare each completing memory transaction.
  always @(negedge clk) begin
    if (!rst && (mem_read || mem_write) && !mem_busywait) begin
      chk("mem_excl", {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_q.size() == 0) begin
        chk("mem_unexpected", 32'd1, 32'd0);
      end else begin
        mem_op_t e;
        e = mem_q.pop_front();
        chk("mem_op", {31'b0, mem_write}, {31'b0, e.wr});
        chk("mem_addr", {26'b0, mem_address}, {26'b0, e.addr});
        if (e.wr) chk("mem_wdata", mem_writedata, e.data);
      end
    end
  end

  task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
    mem_op_t e;
    e.wr = wr; e.addr = a; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int stall);
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = wd;
    stall = 0;
    #1;
    while (busywait && stall < 200) begin
      @(negedge clk);
      #1;
      stall++;
    end
    chk("stall_timeout", {31'b0, busywait}, 32'd0);
    if (rd && !wr) chk("readdata", {24'b0, readdata}, {24'b0, rd_q.pop_front()});
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, output int stall);
    rd_q.push_back(exp);
    access(1'b1, 1'b0, a, 8'h00, stall);
  endtask

  initial begin
    int st;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h00] = 32'h44332211;
    mem[6'h08] = 32'h88776655;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h01] = 32'h01020304;
    mem[6'h10] = 32'hCAFEF00D;

    #1;
    chk("rst_busywait", {31'b0, busywait}, 32'd0);
    chk("rst_readdata", {24'b0, readdata}, 32'd0);
    chk("rst_mem_req", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", {26'b0, mem_address}, 32'd0);
    chk("rst_mem_wdata", mem_writedata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean miss, then hits in the same block.
    push_mem(1'b0, 6'h00, 32'h0);
    do_read(8'h00, 8'h11, st);
    chk("miss_stalls", {31'b0, st > 0}, 32'd1);
    do_read(8'h02, 8'h33, st);
    chk("hit_nostall", st, 0);

    // Write hit then read back.
    access(1'b0, 1'b1, 8'h01, 8'hAA, st);
    chk("whit_nostall", st, 0);
    do_read(8'h01, 8'hAA, st);

    // Dirty eviction of block 0 by tag 1.
    push_mem(1'b1, 6'h00, 32'h4433AA11);
    push_mem(1'b0, 6'h08, 32'h0);
    do_read(8'h20, 8'h55, st);
    chk("dirty_miss_stalls", {31'b0, st > 0}, 32'd1);

    // Write miss allocates, then dirty eviction of index 1.
    push_mem(1'b0, 6'h09, 32'h0);
    access(1'b0, 1'b1, 8'h24, 8'h77, st);
    do_read(8'h24, 8'h77, st);
    chk("wmiss_then_hit", st, 0);
    push_mem(1'b1, 6'h09, 32'hDDCCBB77);
    push_mem(1'b0, 6'h01, 32'h0);
    do_read(8'h04, 8'h04, st);
    do_read(8'h07, 8'h01, st);

    // Reset during FETCH aborts the request.
    @(negedge clk);
    read = 1'b1; address = 8'h40;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_seen", {31'b0, mem_read}, 32'd1);
    chk("fetch_addr", {26'b0, mem_address}, 32'h10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
    chk("abort_busywait", {31'b0, busywait}, 32'd0);
    read = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    push_mem(1'b0, 6'h00, 32'h0);
    do_read(8'h00, 8'h11, st);
    chk("post_reset_miss", {31'b0, st > 0}, 32'd1);

    // READ and WRITE together act as a write.
    access(1'b1, 1'b1, 8'h03, 8'h5C, st);
    chk("rw_nostall", st, 0);
    do_read(8'h03, 8'h5C, st);

    repeat (3) @(negedge clk);
    chk("mem_q_empty", mem_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
